sm83_bus_ctl: RTL and testbench

SM83_BUS_CTL -- requirements
Module: sm83_bus_ctl

---
 rtl/sm83_pkg.sv | 5 +
 rtl/sm83_bus_ctl.sv | 77 +++++++
 tb/tb_sm83_bus_ctl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared SM83 bus-cycle state encoding and high-page constant.
package sm83_pkg;
   typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} bus_state_t;
   localparam logic [7:0] HI_PAGE = 8'hFF;
endpackage

// File: rtl/sm83_bus_ctl.sv
// sm83_bus_ctl: four-phase SM83 bus cycle sequencer with wait states and internal high-page decode.
module sm83_bus_ctl
   import sm83_pkg::*;
#(
   parameter int ADR_WIDTH  = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADR_WIDTH-1:0]  adr,
   input  logic                  req,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  done,
   output logic                  busy,
   output logic [ADR_WIDTH-1:0]  ext_adr,
   input  logic [DATA_WIDTH-1:0] ext_din,
   output logic [DATA_WIDTH-1:0] ext_dout,
   output logic                  ext_doe,
   output logic                  ext_rd,
   output logic                  ext_wr,
   input  logic                  ext_wait,
   input  logic [DATA_WIDTH-1:0] int_din,
   output logic                  hi_area
);
   bus_state_t            r_state;
   logic [ADR_WIDTH-1:0]  r_adr;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   bus_state_t            w_next;
   logic                  w_busy;
   logic                  w_hi;
   logic                  w_ext;
   logic                  w_start;
   logic                  w_stall;
   assign w_busy  = r_state != IDLE;
   assign w_hi    = w_busy && (r_adr[ADR_WIDTH-1 -: 8] == HI_PAGE);
   assign w_ext   = w_busy && !w_hi;
   assign w_start = req && (r_state == IDLE || r_state == T4);
   assign w_stall = ext_wait && !w_hi;
   always_comb begin
      w_next = w_start ? T1 :
               r_state == T1 ? T2 :
               r_state == T2 ? T3 :
               r_state == T3 ? (w_stall ? T3 : T4) : IDLE;
   end
   // State and holding registers move on the falling edge, in step with the upstream address latch.
   always_ff @(negedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_adr   <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_adr   <= adr;
            r_we    <= we;
            r_wdata <= wdata;
         end
         if (r_state == T3 && !w_stall && !r_we)
            r_rdata <= w_hi ? int_din : ext_din;
      end
   end
   assign busy     = w_busy;
   assign hi_area  = w_hi;
   assign done     = r_state == T4;
   assign ext_adr  = r_adr;
   assign ext_dout = r_wdata;
   assign rdata    = r_rdata;
   assign ext_rd   = w_ext && !r_we && (r_state == T1 || r_state == T2 || r_state == T3);
   assign ext_wr   = w_ext && r_we && (r_state == T2 || r_state == T3);
   assign ext_doe  = w_ext && r_we && (r_state == T2 || r_state == T3 || r_state == T4);
endmodule

// File: tb/tb_sm83_bus_ctl.sv
// tb_sm83_bus_ctl: directed checks of read, write, wait, high-page, back-to-back and reset-abort cycles.
module tb_sm83_bus_ctl;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] adr;
   logic        req;
   logic        we;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        done;
   logic        busy;
   logic [15:0] ext_adr;
   logic [7:0]  ext_din;
   logic [7:0]  ext_dout;
   logic        ext_doe;
   logic        ext_rd;
   logic        ext_wr;
   logic        ext_wait;
   logic [7:0]  int_din;
   logic        hi_area;
   int          n_checks = 0;
   int          n_fails = 0;
   sm83_bus_ctl dut (
      .clk(clk), .reset(reset), .adr(adr), .req(req), .we(we), .wdata(wdata),
      .rdata(rdata), .done(done), .busy(busy), .ext_adr(ext_adr), .ext_din(ext_din),
      .ext_dout(ext_dout), .ext_doe(ext_doe), .ext_rd(ext_rd), .ext_wr(ext_wr),
      .ext_wait(ext_wait), .int_din(int_din), .hi_area(hi_area)
   );
   always #5 clk = ~clk;
   // The DUT acts on negedge; the bench samples and drives on posedge, half a cycle away.
   task automatic tick();
      @(posedge clk);
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; adr = '0; wdata = '0;
      ext_din = '0; ext_wait = 1'b0; int_din = '0;
      repeat (3) tick();
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_ext_adr", 32'(ext_adr), 0);
      check("rst_rd", 32'(ext_rd), 0);
      check("rst_wr", 32'(ext_wr), 0);
      check("rst_doe", 32'(ext_doe), 0);
      check("rst_hi", 32'(hi_area), 0);
      reset = 1'b0;
      // external read
      adr = 16'h1234; we = 1'b0; req = 1'b1;
      tick();
      req = 1'b0; adr = 16'h0000;
      check("rd_t1_rd", 32'(ext_rd), 1);
      check("rd_t1_busy", 32'(busy), 1);
      check("rd_t1_adr", 32'(ext_adr), 32'h1234);
      tick();
      check("rd_t2_rd", 32'(ext_rd), 1);
      tick();
      check("rd_t3_rd", 32'(ext_rd), 1);
      check("rd_t3_done", 32'(done), 0);
      ext_din = 8'h5A;
      tick();
      check("rd_t4_done", 32'(done), 1);
      check("rd_t4_rd", 32'(ext_rd), 0);
      check("rd_t4_rdata", 32'(rdata), 32'h5A);
      tick();
      check("rd_idle_busy", 32'(busy), 0);
      check("rd_idle_done", 32'(done), 0);
      check("rd_idle_adr", 32'(ext_adr), 32'h1234);
      // external write; inputs change after capture
      adr = 16'hC000; we = 1'b1; wdata = 8'hA5; req = 1'b1;
      tick();
      req = 1'b0; wdata = 8'h00; adr = 16'h0000; we = 1'b0;
      check("wr_t1_doe", 32'(ext_doe), 0);
      check("wr_t1_wr", 32'(ext_wr), 0);
      check("wr_t1_rd", 32'(ext_rd), 0);
      tick();
      check("wr_t2_doe", 32'(ext_doe), 1);
      check("wr_t2_wr", 32'(ext_wr), 1);
      check("wr_t2_dout", 32'(ext_dout), 32'hA5);
      check("wr_t2_rd", 32'(ext_rd), 0);
      tick();
      check("wr_t3_doe", 32'(ext_doe), 1);
      check("wr_t3_wr", 32'(ext_wr), 1);
      check("wr_t3_rd", 32'(ext_rd), 0);
      tick();
      check("wr_t4_doe", 32'(ext_doe), 1);
      check("wr_t4_wr", 32'(ext_wr), 0);
      check("wr_t4_done", 32'(done), 1);
      check("wr_t4_rdata", 32'(rdata), 32'h5A);
      check("wr_t4_adr", 32'(ext_adr), 32'hC000);
      tick();
      check("wr_idle_doe", 32'(ext_doe), 0);
      check("wr_idle_busy", 32'(busy), 0);
      // wait states: wait high during T1/T2 is ignored, then holds T3 for three extra cycles
      adr = 16'h2000; we = 1'b0; req = 1'b1; ext_wait = 1'b1; ext_din = 8'h11;
      tick();
      req = 1'b0;
      check("wt_t1_rd", 32'(ext_rd), 1);
      tick();
      check("wt_t2_rd", 32'(ext_rd), 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("wt_t3_done", 32'(done), 0);
         check("wt_t3_rd", 32'(ext_rd), 1);
      end
      ext_wait = 1'b0; ext_din = 8'h77;
      tick();
      check("wt_t4_done", 32'(done), 1);
      check("wt_t4_rdata", 32'(rdata), 32'h77);
      tick();
      check("wt_idle_busy", 32'(busy), 0);
      // high page: internal data, no strobes, wait ignored
      adr = 16'hFF44; we = 1'b0; req = 1'b1; ext_wait = 1'b1; int_din = 8'h90; ext_din = 8'h33;
      tick();
      req = 1'b0;
      check("hi_t1_hi", 32'(hi_area), 1);
      check("hi_t1_rd", 32'(ext_rd), 0);
      tick();
      check("hi_t2_rd", 32'(ext_rd), 0);
      check("hi_t2_wr", 32'(ext_wr), 0);
      check("hi_t2_doe", 32'(ext_doe), 0);
      tick();
      check("hi_t3_rd", 32'(ext_rd), 0);
      tick();
      check("hi_t4_done", 32'(done), 1);
      check("hi_t4_rdata", 32'(rdata), 32'h90);
      tick();
      check("hi_idle_hi", 32'(hi_area), 0);
      check("hi_idle_busy", 32'(busy), 0);
      ext_wait = 1'b0;
      // back-to-back: three reads, done every fourth cycle
      adr = 16'h1000; we = 1'b0; req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("b2b_t1_done", 32'(done), 0);
         check("b2b_t1_rd", 32'(ext_rd), 1);
         tick();
         tick();
         check("b2b_t3_done", 32'(done), 0);
         ext_din = 8'(k + 1);
         tick();
         check("b2b_t4_done", 32'(done), 1);
         check("b2b_t4_rdata", 32'(rdata), 32'(k + 1));
         if (k == 2) req = 1'b0;
      end
      tick();
      check("b2b_idle_busy", 32'(busy), 0);
      // reset in T2 of the second back-to-back access
      req = 1'b1; ext_din = 8'h99;
      repeat (4) tick();
      check("ra_t4_done", 32'(done), 1);
      check("ra_t4_rdata", 32'(rdata), 32'h99);
      tick();
      tick();
      check("ra_t2_rd", 32'(ext_rd), 1);
      reset = 1'b1;
      tick();
      check("ra_busy", 32'(busy), 0);
      check("ra_done", 32'(done), 0);
      check("ra_rd", 32'(ext_rd), 0);
      check("ra_hi", 32'(hi_area), 0);
      reset = 1'b0; req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ra_post_done", 32'(done), 0);
         check("ra_post_busy", 32'(busy), 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
